// File: rtl/tile_plane_shifter.sv
// rtl/tile_plane_shifter.sv - multi-bitplane tile row shifter with a one-deep holding register
//
// Purpose: accepts one tile row (PLANES bitplanes of WIDTH pixels plus an
// attribute) into a holding register, then shifts it out one pixel per
// ce_pix cycle. The holding register is refilled while the current row
// shifts, so rows abut with no gap pixel when supply keeps up.
//
// Ports:
//   clock, reset_n        clock, asynchronous active-low reset
//   ce_pix                pixel enable, one pixel advances per enabled cycle
//   flush                 synchronous clear of all pipeline state
//   in_valid / in_ready   tile row handshake; in_ready = holding register empty
//   in_data               plane p in [p*WIDTH +: WIDTH], MSB = leftmost pixel
//   in_flip               mirror this row horizontally at acceptance
//   in_attr               per-tile attribute
//   pix_out               bit p = current pixel of plane p
//   attr_out              attribute of the row currently shifting
//   pix_valid             shifter holds a live row
//   underrun              one-cycle pulse when a row ends with no successor held

module tile_plane_shifter #(
  parameter int PLANES = 4,
  parameter int WIDTH  = 8,
  parameter int ATTR_W = 4
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic                      ce_pix,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [PLANES*WIDTH-1:0]   in_data,
  input  logic                      in_flip,
  input  logic [ATTR_W-1:0]         in_attr,
  output logic [PLANES-1:0]         pix_out,
  output logic [ATTR_W-1:0]         attr_out,
  output logic                      pix_valid,
  output logic                      underrun
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [PLANES*WIDTH-1:0] hold_data_q, hold_data_d;
  logic [ATTR_W-1:0]       hold_attr_q, hold_attr_d;
  logic                    hold_full_q, hold_full_d;
  logic [PLANES*WIDTH-1:0] shift_q, shift_d;
  logic [ATTR_W-1:0]       attr_q, attr_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic                    active_q, active_d;
  logic                    underrun_q, underrun_d;

  logic [PLANES*WIDTH-1:0] flip_data;
  logic [PLANES*WIDTH-1:0] load_data;
  logic [PLANES*WIDTH-1:0] shifted;
  logic                    accept;
  logic                    boundary;

  // Mirroring is applied once at acceptance so the shifter itself only
  // ever shifts left, regardless of orientation.
  always_comb begin
    flip_data = '0;
    shifted   = '0;
    for (int p = 0; p < PLANES; p++) begin
      for (int i = 0; i < WIDTH; i++) begin
        flip_data[p*WIDTH + i] = in_data[p*WIDTH + WIDTH - 1 - i];
      end
      shifted[p*WIDTH +: WIDTH] = {shift_q[p*WIDTH +: WIDTH-1], 1'b0};
    end
  end

  assign load_data = in_flip ? flip_data : in_data;
  assign accept    = in_valid && !hold_full_q;
  // A boundary is the cycle where the shifter may take a new row: either it
  // is idle or it is showing the last pixel of the current row.
  assign boundary  = ce_pix && (!active_q || (cnt_q == LAST));

  always_comb begin
    hold_data_d = hold_data_q;
    hold_attr_d = hold_attr_q;
    hold_full_d = hold_full_q;
    shift_d     = shift_q;
    attr_d      = attr_q;
    cnt_d       = cnt_q;
    active_d    = active_q;
    underrun_d  = 1'b0;

    if (flush) begin
      hold_full_d = 1'b0;
      shift_d     = '0;
      attr_d      = '0;
      cnt_d       = '0;
      active_d    = 1'b0;
    end else begin
      if (boundary) begin
        cnt_d = '0;
        if (hold_full_q) begin
          shift_d     = hold_data_q;
          attr_d      = hold_attr_q;
          active_d    = 1'b1;
          hold_full_d = 1'b0;
        end else begin
          shift_d    = '0;
          active_d   = 1'b0;
          underrun_d = active_q;
        end
      end else if (ce_pix) begin
        shift_d = shifted;
        cnt_d   = cnt_q + 1'b1;
      end

      // accept needs hold_full_q == 0 while a transfer needs it set, so the
      // two never touch hold_full_d in the same cycle.
      if (accept) begin
        hold_data_d = load_data;
        hold_attr_d = in_attr;
        hold_full_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      hold_data_q <= '0;
      hold_attr_q <= '0;
      hold_full_q <= 1'b0;
      shift_q     <= '0;
      attr_q      <= '0;
      cnt_q       <= '0;
      active_q    <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      hold_data_q <= hold_data_d;
      hold_attr_q <= hold_attr_d;
      hold_full_q <= hold_full_d;
      shift_q     <= shift_d;
      attr_q      <= attr_d;
      cnt_q       <= cnt_d;
      active_q    <= active_d;
      underrun_q  <= underrun_d;
    end
  end

  always_comb begin
    pix_out = '0;
    for (int p = 0; p < PLANES; p++) begin
      pix_out[p] = shift_q[p*WIDTH + WIDTH - 1];
    end
  end

  assign in_ready  = !hold_full_q;
  assign attr_out  = attr_q;
  assign pix_valid = active_q;
  assign underrun  = underrun_q;

endmodule

// File: tb/tb_tile_plane_shifter.sv
// tb/tb_tile_plane_shifter.sv - self-checking bench for tile_plane_shifter

module tb_tile_plane_shifter;

  localparam int P = 4;
  localparam int W = 8;
  localparam int A = 4;

  logic           clock    = 1'b0;
  logic           reset_n  = 1'b0;
  logic           ce_pix   = 1'b0;
  logic           flush    = 1'b0;
  logic           in_valid = 1'b0;
  logic           in_flip  = 1'b0;
  logic [P*W-1:0] in_data  = '0;
  logic [A-1:0]   in_attr  = '0;
  logic           in_ready;
  logic [P-1:0]   pix_out;
  logic [A-1:0]   attr_out;
  logic           pix_valid;
  logic           underrun;

  tile_plane_shifter #(.PLANES(P), .WIDTH(W), .ATTR_W(A)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .ce_pix    (ce_pix),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_flip   (in_flip),
    .in_attr   (in_attr),
    .pix_out   (pix_out),
    .attr_out  (attr_out),
    .pix_valid (pix_valid),
    .underrun  (underrun)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Model: a row is a list of pixel columns, leftmost first. The current row
  // is consumed from the front, one column per enabled pixel cycle.
  logic [P-1:0] pixq[$];
  logic [P-1:0] held[$];
  logic         has_held  = 1'b0;
  logic [A-1:0] held_attr = '0;
  logic [A-1:0] last_attr = '0;
  logic         exp_und   = 1'b0;

  initial forever begin
    @(posedge clock or negedge reset_n);
    if (!reset_n || flush) begin
      pixq.delete();
      held.delete();
      has_held  = 1'b0;
      last_attr = '0;
      exp_und   = 1'b0;
    end else begin
      logic acc;
      acc     = in_valid && !has_held;
      exp_und = 1'b0;
      if (ce_pix) begin
        if (pixq.size() <= 1) begin
          if (has_held) begin
            pixq      = held;
            last_attr = held_attr;
            has_held  = 1'b0;
          end else begin
            if (pixq.size() == 1) exp_und = 1'b1;
            pixq.delete();
          end
        end else begin
          void'(pixq.pop_front());
        end
      end
      if (acc) begin
        has_held  = 1'b1;
        held_attr = in_attr;
        held.delete();
        for (int i = 0; i < W; i++) begin
          logic [P-1:0] col;
          for (int p = 0; p < P; p++)
            col[p] = in_flip ? in_data[p*W + i] : in_data[p*W + W - 1 - i];
          held.push_back(col);
        end
      end
    end
  end

  initial forever begin
    @(negedge clock);
    chk("pix_out",   pix_out,   (pixq.size() > 0) ? pixq[0] : '0);
    chk("pix_valid", pix_valid, pixq.size() > 0);
    chk("attr_out",  attr_out,  last_attr);
    chk("in_ready",  in_ready,  !has_held);
    chk("underrun",  underrun,  exp_und);
  end

  logic [31:0]  cap_rec;
  int           cap_nv;
  int           cap_nu;
  logic [A-1:0] cap_attr [32];
  logic         tog = 1'b0;

  task automatic send_tile(input logic [P*W-1:0] d, input logic f, input logic [A-1:0] a);
    int t;
    t = 0;
    @(negedge clock);
    while (!in_ready && t < 50) begin
      @(negedge clock);
      t++;
    end
    chk("send_wait_ready", in_ready, 1);
    in_valid = 1'b1;
    in_data  = d;
    in_flip  = f;
    in_attr  = a;
    @(negedge clock);
    in_valid = 1'b0;
    chk("ready_drop_after_accept", in_ready, 0);
  endtask

  task automatic capture(input int n, input int plane);
    cap_rec = '0;
    cap_nv  = 0;
    cap_nu  = 0;
    repeat (n) begin
      @(negedge clock);
      if (pix_valid) begin
        if (cap_nv < 32) cap_attr[cap_nv] = attr_out;
        cap_rec = {cap_rec[30:0], pix_out[plane]};
        cap_nv++;
      end
      if (underrun) cap_nu++;
      if (tog) ce_pix = ~ce_pix;
    end
  endtask

  task automatic setup_held();
    ce_pix = 1'b1;
    send_tile(32'h0000_000F, 1'b0, 4'd7);
    send_tile(32'h0000_00F0, 1'b0, 4'd8);
    repeat (2) @(negedge clock);
    chk("pre_clear_held", in_ready, 0);
    chk("pre_clear_valid", pix_valid, 1);
  endtask

  initial begin
    repeat (3) @(negedge clock);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_pix_valid", pix_valid, 0);
    chk("rst_pix_out", pix_out, 0);
    chk("rst_attr_out", attr_out, 0);
    chk("rst_underrun", underrun, 0);
    reset_n = 1'b1;
    ce_pix  = 1'b1;

    fork
      send_tile(32'h0000_00A5, 1'b0, 4'd3);
      capture(16, 0);
    join
    chk("a5_seq", cap_rec[7:0], 8'hA5);
    chk("a5_valid_cycles", cap_nv, 8);
    chk("a5_underrun_count", cap_nu, 1);
    chk("a5_attr", cap_attr[0], 4'd3);

    fork
      send_tile(32'h0000_00A5, 1'b1, 4'd3);
      capture(16, 0);
    join
    chk("a5_flip_seq", cap_rec[7:0], 8'hA5);
    chk("a5_flip_valid_cycles", cap_nv, 8);

    fork
      send_tile(32'h0000_0080, 1'b1, 4'd3);
      capture(16, 0);
    join
    chk("x80_flip_seq", cap_rec[7:0], 8'h01);

    fork
      begin
        send_tile(32'hFF00_0000, 1'b0, 4'd1);
        send_tile(32'h0000_0000, 1'b0, 4'd2);
      end
      capture(24, 3);
    join
    chk("b2b_seq", cap_rec[15:0], 16'hFF00);
    chk("b2b_valid_cycles", cap_nv, 16);
    chk("b2b_underrun_count", cap_nu, 1);
    chk("b2b_attr_px8", cap_attr[7], 4'd1);
    chk("b2b_attr_px9", cap_attr[8], 4'd2);

    tog = 1'b1;
    fork
      send_tile(32'h0000_3C00, 1'b0, 4'd5);
      capture(40, 1);
    join
    tog    = 1'b0;
    ce_pix = 1'b1;
    chk("ce_toggle_valid_cycles", cap_nv, 16);
    chk("ce_toggle_underrun_count", cap_nu, 1);
    repeat (2) @(negedge clock);

    setup_held();
    flush = 1'b1;
    @(negedge clock);
    flush = 1'b0;
    chk("flush_pix_valid", pix_valid, 0);
    chk("flush_in_ready", in_ready, 1);
    chk("flush_pix_out", pix_out, 0);
    chk("flush_attr_out", attr_out, 0);
    chk("flush_underrun", underrun, 0);
    capture(12, 0);
    chk("flush_no_resume", cap_nv, 0);
    chk("flush_no_underrun", cap_nu, 0);

    setup_held();
    #2 reset_n = 1'b0;
    #1;
    chk("arst_pix_valid", pix_valid, 0);
    chk("arst_in_ready", in_ready, 1);
    chk("arst_pix_out", pix_out, 0);
    chk("arst_attr_out", attr_out, 0);
    chk("arst_underrun", underrun, 0);
    @(negedge clock);
    reset_n = 1'b1;

    fork
      send_tile(32'h0000_00A5, 1'b0, 4'd9);
      capture(16, 0);
    join
    chk("resume_seq", cap_rec[7:0], 8'hA5);
    chk("resume_valid_cycles", cap_nv, 8);
    chk("resume_attr", cap_attr[0], 4'd9);

    repeat (2) @(negedge clock);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tile_plane_shifter.md
TILE_PLANE_SHIFTER -- requirements
Module: tile_plane_shifter

Interface
REQ-001 Parameter PLANES, default 4, number of bitplanes shifted in parallel (1..8).
REQ-002 Parameter WIDTH, default 8, pixels per tile row per plane (2..16).
REQ-003 Parameter ATTR_W, default 4, width of per-tile attribute carried alongside pixels.
REQ-004 clock  input  1  single clock; all state SHALL update on its rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 ce_pix  input  1  pixel clock enable; one pixel advances per cycle with ce_pix=1.
REQ-007 flush  input  1  synchronous clear of all pipeline state (line start).
REQ-008 in_valid  input  1  tile row offered.
REQ-009 in_ready  output  1  holding register empty; equals !hold_full, registered-state-derived, no combinational path from in_valid.
REQ-010 in_data  input  PLANES*WIDTH  plane p in bits [p*WIDTH +: WIDTH], MSB = leftmost pixel.
REQ-011 in_flip  input  1  mirror this tile row horizontally.
REQ-012 in_attr  input  ATTR_W  per-tile attribute.
REQ-013 pix_out  output  PLANES  bit p = MSB of plane p shift register.
REQ-014 attr_out  output  ATTR_W  attribute of tile currently shifting.
REQ-015 pix_valid  output  1  shifter holds a live tile.
REQ-016 underrun  output  1  one-cycle pulse when a tile ends with no successor ready.

Function
REQ-017 State: holding regs (data, flip, attr, hold_full), shift regs PLANES x WIDTH, attr reg, counter cnt 0..WIDTH-1, active flag.
REQ-018 Accept: in_valid && in_ready at an edge SHALL store in_data/in_flip/in_attr in holding regs and set hold_full.
REQ-019 Flip: at acceptance, if in_flip=1, each plane's WIDTH bits SHALL be stored bit-reversed; else unchanged.
REQ-020 Boundary: boundary = ce_pix && (!active || cnt==WIDTH-1).
REQ-021 Boundary with hold_full=1: shift regs <= holding data, attr reg <= holding attr, cnt <= 0, active <= 1, hold_full <= 0.
REQ-022 Boundary with hold_full=0: active <= 0, shift regs <= 0, cnt <= 0; underrun SHALL pulse for one cycle only if active was 1.
REQ-023 Non-boundary ce_pix with active=1: each plane shifts left one, LSB filled 0, cnt <= cnt+1.
REQ-024 ce_pix=0: shift regs, cnt, active, attr reg SHALL hold; accepts still occur.
REQ-025 Since in_ready=!hold_full at edge start, accept and transfer SHALL never coincide on the same holding contents; a transfer frees the holding reg, and in_ready rises the next cycle.
REQ-026 Latency: tile accepted at edge t is first visible on pix_out after the first boundary edge > t; with continuous ce_pix and supply, tiles SHALL abut with no gap pixel.
REQ-027 pix_out, attr_out, pix_valid SHALL be driven directly from registers (no combinational logic from inputs).
REQ-028 flush=1 at an edge SHALL clear hold_full, active, cnt, shift regs, attr reg, suppress underrun, and override accept, transfer and shift in that cycle.

Reset
REQ-029 reset_n=0 SHALL immediately clear: hold_full=0 (in_ready=1), active=0, cnt=0, shift regs=0, attr reg=0, pix_out=0, attr_out=0, pix_valid=0, underrun=0.
REQ-030 Reset asserted mid-tile SHALL discard both shifting and held tiles; operation resumes from empty on first edge after release.

Verification (PLANES=4, WIDTH=8, ATTR_W=4)
REQ-031 Load plane0=0xA5, others 0, flip=0, attr=3, ce_pix=1 continuous -> pix_out[0] sequence 1,0,1,0,0,1,0,1; attr_out=3; pix_valid=1 for exactly 8 ce cycles, then underrun pulse once, pix_valid=0.
REQ-032 Same with flip=1 -> pix_out[0] sequence 1,0,1,0,0,1,0,1 reversed of 0xA5 = 0xA5 (palindrome); repeat with 0x80 -> first pixel 0, eighth pixel 1.
REQ-033 Two tiles back-to-back (0xFF then 0x00 on plane3, attrs 1 and 2) -> 8 ones then 8 zeros on pix_out[3], attr_out switches 1->2 at pixel 9, no underrun between.
REQ-034 ce_pix toggling 1/0 -> each pixel held two cycles; in_ready drops after accept and rises one cycle after transfer.
REQ-035 flush and reset_n=0 asserted at pixel 4 with a tile held -> all outputs 0 immediately (reset) or next edge (flush), in_ready=1, no underrun pulse.
